wb_port_arbiter: RTL

Shares the register file's single write port between the in-order pipeline writeback and a long-latency unit (LU, e.g. the multi-cycle mul/div). Pipeline writes always win. LU results wait in a small in-order buffer and drain in idle write slots. The block sits between the writeback stage, the LU and the register file. It also kills stale buffered results on write-after-write and raises a stall request when the buffer is starved of write slots.

---
 rtl/wb_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between pipeline writeback
//            and a long-latency unit via a small in-order result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ws_reg_wen,
  input  logic [4:0]               ws_rd,
  input  logic [31:0]              ws_reg_wdata,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_wdata,
  output logic                     rf_wen,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_SW = 4;

  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [c_AW-1:0]  r_head;
  logic [c_AW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;
  logic [c_SW-1:0]  r_starve;
  logic             r_stall;
  logic             r_rf_wen;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;

  logic             w_pipe_wr;
  logic             w_lu_acc;
  logic             w_push;
  logic             w_empty;
  logic             w_head_live;
  logic             w_drain;
  logic             w_dead_pop;
  logic             w_pop;
  logic [c_CW-1:0]  w_count_next;
  logic [c_SW-1:0]  w_starve_next;

  assign w_pipe_wr   = ws_reg_wen && (ws_rd != 5'd0);
  // Credit comes only from the registered count, never from a same-cycle pop.
  assign lu_ready    = !rst && (r_count < c_CW'(DEPTH));
  assign w_lu_acc    = lu_valid && lu_ready;
  // Results to x0 or already overwritten by writeback are accepted but dropped.
  assign w_push      = w_lu_acc && (lu_rd != 5'd0) && !(w_pipe_wr && (lu_rd == ws_rd));
  assign w_empty     = (r_count == '0);
  assign w_head_live = !w_empty && r_live[r_head];
  assign w_drain     = !w_pipe_wr && w_head_live;
  assign w_dead_pop  = !w_empty && !r_live[r_head];
  assign w_pop       = w_drain || w_dead_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CW'(1);
      2'b01:   w_count_next = r_count - c_CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_drain || w_empty) begin
      w_starve_next = '0;
    end else if (w_head_live && (r_starve != c_SW'(STARVE_LIMIT))) begin
      w_starve_next = r_starve + c_SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_live     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_stall    <= 1'b0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      // Buffered LU results are always older than the writeback instruction.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pipe_wr && (r_rd[i] == ws_rd)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_live[r_tail] <= 1'b1;
        r_tail         <= r_tail + c_AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_AW'(1);
      end
      r_count  <= w_count_next;
      r_starve <= w_starve_next;
      r_stall  <= (w_starve_next == c_SW'(STARVE_LIMIT));
      r_rf_wen <= w_pipe_wr || w_drain;
      if (w_pipe_wr) begin
        r_rf_waddr <= ws_rd;
        r_rf_wdata <= ws_reg_wdata;
      end else if (w_drain) begin
        r_rf_waddr <= r_rd[r_head];
        r_rf_wdata <= r_data[r_head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= lu_rd;
      r_data[r_tail] <= lu_wdata;
    end
  end

  assign rf_wen    = r_rf_wen;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign stall_req = r_stall;
  assign buf_count = r_count;

endmodule

`default_nettype wire
